// File: rtl/gfx_cmd_pkg.sv
// Shared opcode, payload-length, engine-index and dispatcher-state definitions
// for the graphics command front end and its decode engines.
package gfx_cmd_pkg;

  localparam logic [7:0] OP_FILL_RECT = 8'h01;
  localparam logic [7:0] OP_LINE      = 8'h02;
  localparam logic [7:0] OP_BLIT      = 8'h03;
  localparam logic [7:0] OP_CLEAR     = 8'h04;

  localparam logic [3:0] LEN_FILL_RECT = 4'd11;
  localparam logic [3:0] LEN_LINE      = 4'd11;
  localparam logic [3:0] LEN_BLIT      = 4'd12;
  localparam logic [3:0] LEN_CLEAR     = 4'd3;

  localparam logic [1:0] ENG_FILL_RECT = 2'd0;
  localparam logic [1:0] ENG_LINE      = 2'd1;
  localparam logic [1:0] ENG_BLIT      = 2'd2;
  localparam logic [1:0] ENG_CLEAR     = 2'd3;

  typedef enum logic [1:0] {
    DISP_FETCH   = 2'd0,
    DISP_HOLD    = 2'd1,
    DISP_PAYLOAD = 2'd2
  } disp_state_t;

  typedef struct packed {
    logic       legal;
    logic [1:0] eng_idx;
    logic [3:0] len;
  } op_info_t;

endpackage

// File: rtl/gfx_opcode_lut.sv
// Combinational opcode decode: opcode byte -> {legal, target engine, payload length}.
module gfx_opcode_lut
  import gfx_cmd_pkg::*;
(
  input  logic [7:0] opcode,
  output op_info_t   info
);

  always_comb begin
    info = '0;
    case (opcode)
      OP_FILL_RECT: info = '{legal: 1'b1, eng_idx: ENG_FILL_RECT, len: LEN_FILL_RECT};
      OP_LINE:      info = '{legal: 1'b1, eng_idx: ENG_LINE,      len: LEN_LINE};
      OP_BLIT:      info = '{legal: 1'b1, eng_idx: ENG_BLIT,      len: LEN_BLIT};
      OP_CLEAR:     info = '{legal: 1'b1, eng_idx: ENG_CLEAR,     len: LEN_CLEAR};
      default:      info = '0;
    endcase
  end

endmodule

// File: rtl/gfx_cmd_dispatcher.sv
// Command front end: fetches an opcode byte, optionally waits for the target engine(s)
// to go idle, then passes exactly the opcode's payload bytes through to that engine.
module gfx_cmd_dispatcher
  import gfx_cmd_pkg::*;
#(
  parameter int NUM_ENG   = 4,
  parameter bit SERIALIZE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_fifo_rts,
  input  logic [7:0]         cmd_fifo_data,
  output logic               cmd_fifo_rtr,
  output logic [NUM_ENG-1:0] eng_rts,
  output logic [7:0]         eng_data,
  input  logic [NUM_ENG-1:0] eng_rtr,
  input  logic [NUM_ENG-1:0] eng_busy,
  output logic               bad_opcode,
  output logic [15:0]        cmd_count,
  output logic [1:0]         disp_state
);

  // Handshake: a byte moves on either side only in a cycle where rts and rtr are both 1;
  // rts never depends on rtr, and data is held stable while rts=1 and rtr=0.

  disp_state_t state;
  logic [1:0]  tgt;
  logic [3:0]  remaining;
  op_info_t    info;
  logic        fifo_xfer;
  logic        wait_new;
  logic        wait_cur;

  gfx_opcode_lut u_lut (
    .opcode (cmd_fifo_data),
    .info   (info)
  );

  assign fifo_xfer  = cmd_fifo_rts & cmd_fifo_rtr;
  assign wait_new   = SERIALIZE ? (|eng_busy) : eng_busy[info.eng_idx];
  assign wait_cur   = SERIALIZE ? (|eng_busy) : eng_busy[tgt];
  assign disp_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DISP_FETCH;
      tgt        <= '0;
      remaining  <= '0;
      cmd_count  <= '0;
      bad_opcode <= 1'b0;
    end else begin
      bad_opcode <= 1'b0;
      case (state)
        DISP_HOLD: begin
          if (!wait_cur) state <= DISP_PAYLOAD;
        end
        DISP_PAYLOAD: begin
          if (fifo_xfer) begin
            remaining <= remaining - 4'd1;
            if (remaining == 4'd1) begin
              state     <= DISP_FETCH;
              cmd_count <= cmd_count + 16'd1;
            end
          end
        end
        // Unused encoding 3 behaves as FETCH.
        default: begin
          if (fifo_xfer) begin
            if (info.legal) begin
              tgt       <= info.eng_idx;
              remaining <= info.len;
              state     <= wait_new ? DISP_HOLD : DISP_PAYLOAD;
            end else begin
              bad_opcode <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Payload path is a zero-latency pass-through from the FIFO to the selected engine.
  always_comb begin
    cmd_fifo_rtr = 1'b0;
    eng_rts      = '0;
    eng_data     = cmd_fifo_data;
    if (!rst) begin
      case (state)
        DISP_HOLD: cmd_fifo_rtr = 1'b0;
        DISP_PAYLOAD: begin
          eng_rts[tgt] = cmd_fifo_rts;
          cmd_fifo_rtr = eng_rtr[tgt];
        end
        default: cmd_fifo_rtr = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_cmd_dispatcher.sv
// Directed bench for gfx_cmd_dispatcher: opcode table vectors plus multi-cycle sequences
// for backpressure, engine overlap/hazards, illegal opcodes and mid-payload reset.
module tb_gfx_cmd_dispatcher;
  import gfx_cmd_pkg::*;

  localparam int W = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_rts = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic [3:0] eng_rtr = 4'hF;
  logic [3:0] eng_busy;
  bit         sel = 1'b0;

  logic       rtr0, rtr1, bad0, bad1;
  logic [3:0] rts0, rts1;
  logic [7:0] data0, data1;
  logic [15:0] count0, count1;
  logic [1:0] st0, st1;

  logic       cur_rtr, cur_bad;
  logic [3:0] cur_rts;
  logic [7:0] cur_data;
  logic [15:0] cur_count;
  logic [1:0] cur_state;

  int cyc = 0;
  int busy_until[4];
  int errors = 0;
  int n_checks = 0;
  int exp_count = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [7:0] op;
    bit         legal;
    int         eng;
    int         len;
  } vec_t;
  vec_t vecs[8];

  // ---------------- clock / devices ----------------
  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int e = 0; e < 4; e++) eng_busy[e] = (cyc < busy_until[e]);
  end

  gfx_cmd_dispatcher #(.NUM_ENG(4), .SERIALIZE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .cmd_fifo_rts(cmd_rts), .cmd_fifo_data(cmd_data),
    .cmd_fifo_rtr(rtr0), .eng_rts(rts0), .eng_data(data0), .eng_rtr(eng_rtr),
    .eng_busy(eng_busy), .bad_opcode(bad0), .cmd_count(count0), .disp_state(st0)
  );

  gfx_cmd_dispatcher #(.NUM_ENG(4), .SERIALIZE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .cmd_fifo_rts(cmd_rts), .cmd_fifo_data(cmd_data),
    .cmd_fifo_rtr(rtr1), .eng_rts(rts1), .eng_data(data1), .eng_rtr(eng_rtr),
    .eng_busy(eng_busy), .bad_opcode(bad1), .cmd_count(count1), .disp_state(st1)
  );

  assign cur_rtr   = sel ? rtr1   : rtr0;
  assign cur_rts   = sel ? rts1   : rts0;
  assign cur_data  = sel ? data1  : data0;
  assign cur_bad   = sel ? bad1   : bad0;
  assign cur_count = sel ? count1 : count0;
  assign cur_state = sel ? st1    : st0;

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cmd_rts = 1'b1;
    cmd_data = OP_CLEAR;
    #1;
    chk("rst_rtr", {31'd0, cur_rtr}, 0);
    chk("rst_rts", {28'd0, cur_rts}, 0);
    @(negedge clk);
    rst = 1'b0;
    cmd_rts = 1'b0;
    for (int e = 0; e < 4; e++) busy_until[e] = 0;
    exp_count = 0;
    exp_q.delete();
    #1;
    chk("rst_state", {30'd0, cur_state}, 0);
    chk("rst_count", {16'd0, cur_count}, 0);
    chk("rst_bad", {31'd0, cur_bad}, 0);
    chk("rst_eng_rts", {28'd0, cur_rts}, 0);
  endtask

  // Present one FIFO byte and wait (bounded) for it to be taken.
  task automatic send(input logic [7:0] b, input bit pay, input int eng, input int gap,
                      input int stall, input int busy_len, input bit first);
    bit done;
    logic bz;
    logic [W-1:0] want;
    if (gap > 0) begin
      cmd_rts = 1'b0;
      for (int g = 0; g < gap; g++) begin
        #1;
        chk("gap_eng_rts", {28'd0, cur_rts}, 0);
        @(negedge clk);
      end
    end
    cmd_rts = 1'b1;
    cmd_data = b;
    if (stall > 0) begin
      eng_rtr[eng] = 1'b0;
      for (int s = 0; s < stall; s++) begin
        #1;
        chk("stall_rtr", {31'd0, cur_rtr}, 0);
        @(negedge clk);
      end
      eng_rtr[eng] = 1'b1;
    end
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      #1;
      if (cur_rtr) begin
        if (pay) begin
          if (first) begin
            bz = sel ? (|eng_busy) : eng_busy[eng];
            chk("start_busy", {31'd0, bz}, 0);
          end
          want = exp_q.pop_front();
          chk("payload", {20'd0, cur_rts, cur_data}, {20'd0, want});
        end
        @(posedge clk);
        done = 1'b1;
        if (busy_len > 0) begin
          #1;
          busy_until[eng] = cyc + busy_len;
        end
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("timeout", 0, 1);
  endtask

  task automatic run_cmd(input logic [7:0] op, input bit legal, input int eng, input int len,
                         input bit exp_hold, input int n_send, input int stall_at,
                         input int gap_at, input int busy_len);
    logic [7:0] d;
    logic [3:0] oh;
    #1;
    chk("fetch_state", {30'd0, cur_state}, 0);
    send(op, 1'b0, 0, 0, 0, 0, 1'b0);
    #1;
    chk("bad_opcode", {31'd0, cur_bad}, {31'd0, !legal});
    if (!legal) begin
      cmd_rts = 1'b0;
      @(negedge clk);
      #1;
      chk("bad_pulse_end", {31'd0, cur_bad}, 0);
      chk("bad_stays_fetch", {30'd0, cur_state}, 0);
    end else begin
      chk("post_op_state", {30'd0, cur_state}, exp_hold ? 32'd1 : 32'd2);
      oh = 4'(1 << eng);
      for (int k = 0; k < n_send; k++) begin
        d = 8'($urandom_range(0, 255));
        exp_q.push_back({oh, d});
        send(d, 1'b1, eng, (k == gap_at) ? 2 : 0, (k == stall_at) ? 3 : 0,
             (k == len - 1) ? busy_len : 0, k == 0);
      end
      if (n_send == len) begin
        exp_count++;
        #1;
        chk("done_state", {30'd0, cur_state}, 0);
        chk("cmd_count", {16'd0, cur_count}, exp_count);
      end
    end
    cmd_rts = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{op: 8'h01, legal: 1'b1, eng: 0, len: 11};
    vecs[1] = '{op: 8'h02, legal: 1'b1, eng: 1, len: 11};
    vecs[2] = '{op: 8'h03, legal: 1'b1, eng: 2, len: 12};
    vecs[3] = '{op: 8'h04, legal: 1'b1, eng: 3, len: 3};
    vecs[4] = '{op: 8'h00, legal: 1'b0, eng: 0, len: 0};
    vecs[5] = '{op: 8'h05, legal: 1'b0, eng: 0, len: 0};
    vecs[6] = '{op: 8'hFF, legal: 1'b0, eng: 0, len: 0};
    vecs[7] = '{op: 8'h04, legal: 1'b1, eng: 3, len: 3};
    for (int e = 0; e < 4; e++) busy_until[e] = 0;

    do_reset();

    // FILL_RECT with free-flowing handshakes
    run_cmd(8'h01, 1'b1, 0, 11, 1'b0, 11, -1, -1, 0);
    // LINE with engine stall and FIFO gap mid-payload
    run_cmd(8'h02, 1'b1, 1, 11, 1'b0, 11, 4, 7, 0);

    // Opcode table sweep
    for (int i = 0; i < 8; i++)
      run_cmd(vecs[i].op, vecs[i].legal, vecs[i].eng, vecs[i].len, 1'b0,
              vecs[i].len, -1, -1, 0);

    // Same-engine hazard: engine 0 busy for 20 cycles after the first payload
    run_cmd(8'h01, 1'b1, 0, 11, 1'b0, 11, -1, -1, 20);
    run_cmd(8'h01, 1'b1, 0, 11, 1'b1, 11, -1, -1, 0);

    // Illegal opcode followed by CLEAR
    do_reset();
    run_cmd(8'h7F, 1'b0, 0, 0, 1'b0, 0, -1, -1, 0);
    run_cmd(8'h04, 1'b1, 3, 3, 1'b0, 3, -1, -1, 0);

    // Reset after 5 of 12 BLIT bytes, then a fresh FILL_RECT
    run_cmd(8'h03, 1'b1, 2, 12, 1'b0, 5, -1, -1, 0);
    do_reset();
    run_cmd(8'h01, 1'b1, 0, 11, 1'b0, 11, -1, -1, 0);

    // CLEAR while engine 0 busy: overlaps without SERIALIZE, held with it
    sel = 1'b0;
    do_reset();
    busy_until[0] = cyc + 15;
    run_cmd(8'h04, 1'b1, 3, 3, 1'b0, 3, -1, -1, 0);
    sel = 1'b1;
    do_reset();
    busy_until[0] = cyc + 15;
    run_cmd(8'h04, 1'b1, 3, 3, 1'b1, 3, -1, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
